// File: rtl/fighter_input_decoder.sv
// Per-player controller word decoder: debounce filter, malformed-word rejection,
// press-edge detection and the attack/parry/cooldown state machine timed in frames.
module fighter_input_decoder #(
   parameter int STABLE_CYCLES    = 4,
   parameter int ATTACK_FRAMES    = 6,
   parameter int PARRY_MAX_FRAMES = 30,
   parameter int COOLDOWN_FRAMES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] ctrl_word,
   input  logic       frame_tick,
   output logic       move_left,
   output logic       move_right,
   output logic       crouch,
   output logic       jump_pulse,
   output logic       attack_pulse,
   output logic       attacking,
   output logic       parrying,
   output logic [1:0] fsm_state,
   output logic       word_error
);

   localparam logic [6:0] IDLE_WORD = 7'b1100001;

   localparam int CNT_MAX   = STABLE_CYCLES - 1;
   localparam int CNT_W     = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int FRAME_MAX = ((ATTACK_FRAMES > PARRY_MAX_FRAMES) ?
                               ((ATTACK_FRAMES > COOLDOWN_FRAMES) ? ATTACK_FRAMES : COOLDOWN_FRAMES) :
                               ((PARRY_MAX_FRAMES > COOLDOWN_FRAMES) ? PARRY_MAX_FRAMES : COOLDOWN_FRAMES)) - 1;
   localparam int FCNT_W    = ($clog2(FRAME_MAX + 1) > 0) ? $clog2(FRAME_MAX + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ATTACK   = 2'd1,
      S_PARRY    = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   logic [6:0]        in_q, stable_q, prev_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   state_t            state_q, state_d;

   logic       word_valid, up_edge, atk_edge, par_edge, free_move;
   logic [6:0] dec_word;
   logic       move_left_d, move_right_d, crouch_d, jump_d, attack_pulse_d;

   // A word is only promoted once it has been seen unchanged for STABLE_CYCLES samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_q     <= IDLE_WORD;
         cnt_q    <= '0;
         stable_q <= IDLE_WORD;
      end else if (ctrl_word != in_q) begin
         in_q  <= ctrl_word;
         cnt_q <= '0;
      end else if (cnt_q < CNT_W'(CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         stable_q <= in_q;
      end
   end

   always_comb begin
      word_valid = $onehot(stable_q[4:0]);
      dec_word   = word_valid ? stable_q : IDLE_WORD;
      up_edge    =  dec_word[3] & ~prev_q[3];
      atk_edge   = ~dec_word[5] &  prev_q[5];
      par_edge   = ~dec_word[6] &  prev_q[6];
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (atk_edge) begin
               state_d = S_ATTACK;
               fcnt_d  = '0;
            end else if (par_edge) begin
               state_d = S_PARRY;
               fcnt_d  = '0;
            end
         end
         S_ATTACK: begin
            if (frame_tick) begin
               if (fcnt_q == FCNT_W'(ATTACK_FRAMES - 1)) begin
                  state_d = S_COOLDOWN;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
         end
         S_PARRY: begin
            if (dec_word[6]) begin
               state_d = S_COOLDOWN;
               fcnt_d  = '0;
            end else if (frame_tick) begin
               if (fcnt_q == FCNT_W'(PARRY_MAX_FRAMES - 1)) begin
                  state_d = S_COOLDOWN;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
         end
         S_COOLDOWN: begin
            if (frame_tick) begin
               if (fcnt_q == FCNT_W'(COOLDOWN_FRAMES - 1)) begin
                  state_d = S_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            fcnt_d  = '0;
         end
      endcase

      // Outputs follow the state being entered so they agree with fsm_state after the edge.
      free_move      = (state_d == S_IDLE) || (state_d == S_COOLDOWN);
      move_left_d    = free_move & dec_word[1];
      move_right_d   = free_move & dec_word[2];
      crouch_d       = free_move & dec_word[4];
      jump_d         = free_move & up_edge;
      attack_pulse_d = (state_q == S_IDLE) && (state_d == S_ATTACK);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fcnt_q       <= '0;
         prev_q       <= IDLE_WORD;
         move_left    <= 1'b0;
         move_right   <= 1'b0;
         crouch       <= 1'b0;
         jump_pulse   <= 1'b0;
         attack_pulse <= 1'b0;
         attacking    <= 1'b0;
         parrying     <= 1'b0;
         word_error   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         prev_q       <= dec_word;
         move_left    <= move_left_d;
         move_right   <= move_right_d;
         crouch       <= crouch_d;
         jump_pulse   <= jump_d;
         attack_pulse <= attack_pulse_d;
         attacking    <= (state_d == S_ATTACK);
         parrying     <= (state_d == S_PARRY);
         word_error   <= ~word_valid;
      end
   end

   assign fsm_state = state_q;

endmodule

// File: tb/tb_fighter_input_decoder.sv
// Scoreboard bench for fighter_input_decoder: a window-based reference model predicts
// every cycle's outputs, a monitor compares them; directed scenarios add spot checks.
module tb_fighter_input_decoder;

   localparam int STABLE_CYCLES    = 4;
   localparam int ATTACK_FRAMES    = 6;
   localparam int PARRY_MAX_FRAMES = 30;
   localparam int COOLDOWN_FRAMES  = 10;

   localparam logic [6:0] W_IDLE  = 7'b1100001;
   localparam logic [6:0] W_LEFT  = 7'b1100010;
   localparam logic [6:0] W_UP    = 7'b1101000;
   localparam logic [6:0] W_ATK   = 7'b1000001;
   localparam logic [6:0] W_ATKUP = 7'b1001000;
   localparam logic [6:0] W_PAR   = 7'b0100001;
   localparam logic [6:0] W_BOTH  = 7'b0000001;
   localparam logic [6:0] W_BAD   = 7'b1100110;

   typedef struct packed {
      logic       ml, mr, cr, jp, ap, at, pa;
      logic [1:0] st;
      logic       we;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] ctrl_word;
   logic       frame_tick;
   logic       move_left, move_right, crouch, jump_pulse, attack_pulse;
   logic       attacking, parrying, word_error;
   logic [1:0] fsm_state;

   int n_compared   = 0;
   int n_mismatched = 0;
   int tick_period  = 8;
   int atk_pulses   = 0;
   int jumps        = 0;

   exp_t exp_q[$];

   fighter_input_decoder #(
      .STABLE_CYCLES   (STABLE_CYCLES),
      .ATTACK_FRAMES   (ATTACK_FRAMES),
      .PARRY_MAX_FRAMES(PARRY_MAX_FRAMES),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl_word   (ctrl_word),
      .frame_tick  (frame_tick),
      .move_left   (move_left),
      .move_right  (move_right),
      .crouch      (crouch),
      .jump_pulse  (jump_pulse),
      .attack_pulse(attack_pulse),
      .attacking   (attacking),
      .parrying    (parrying),
      .fsm_state   (fsm_state),
      .word_error  (word_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Frame ticks: fixed period when tick_period > 0, otherwise random.
   initial begin
      int cyc = 0;
      frame_tick = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (tick_period > 0) frame_tick = (cyc % tick_period) == 0;
         else                 frame_tick = ($urandom_range(0, 2) == 0);
      end
   end

   // Reference model: a word is accepted once the last STABLE_CYCLES+1 samples agree;
   // the fight state counts frame ticks seen since it was entered.
   initial begin
      logic [6:0] hist[$];
      logic [6:0] m_stable, m_prev, w;
      int         m_state, m_ticks, nxt;
      logic       valid, atk, par, up, free, same;
      exp_t       e;
      hist.push_back(W_IDLE);
      m_stable = W_IDLE;
      m_prev   = W_IDLE;
      m_state  = 0;
      m_ticks  = 0;
      forever begin
         @(posedge clk);
         e = '0;
         if (reset) begin
            hist.delete();
            hist.push_back(W_IDLE);
            m_stable = W_IDLE;
            m_prev   = W_IDLE;
            m_state  = 0;
            m_ticks  = 0;
         end else begin
            valid = ($countones(m_stable[4:0]) == 1);
            w     = valid ? m_stable : W_IDLE;
            atk   = m_prev[5] && !w[5];
            par   = m_prev[6] && !w[6];
            up    = !m_prev[3] && w[3];
            nxt   = m_state;
            case (m_state)
               0: if (atk) nxt = 1; else if (par) nxt = 2;
               1: if (frame_tick) begin
                     m_ticks++;
                     if (m_ticks == ATTACK_FRAMES) nxt = 3;
                  end
               2: if (w[6]) nxt = 3;
                  else if (frame_tick) begin
                     m_ticks++;
                     if (m_ticks == PARRY_MAX_FRAMES) nxt = 3;
                  end
               default: if (frame_tick) begin
                     m_ticks++;
                     if (m_ticks == COOLDOWN_FRAMES) nxt = 0;
                  end
            endcase
            if (nxt != m_state) m_ticks = 0;
            free = (nxt == 0) || (nxt == 3);
            e.ml = free && w[1];
            e.mr = free && w[2];
            e.cr = free && w[4];
            e.jp = free && up;
            e.ap = (m_state == 0) && (nxt == 1);
            e.at = (nxt == 1);
            e.pa = (nxt == 2);
            e.st = 2'(nxt);
            e.we = !valid;
            m_state = nxt;
            m_prev  = w;
            hist.push_back(ctrl_word);
            if (hist.size() > STABLE_CYCLES + 1) void'(hist.pop_front());
            if (hist.size() == STABLE_CYCLES + 1) begin
               same = 1'b1;
               foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
               if (same) m_stable = hist[0];
            end
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: every cycle presents a result; compare it against the oldest prediction.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (attack_pulse === 1'b1) atk_pulses++;
         if (jump_pulse === 1'b1)   jumps++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {move_left, move_right, crouch, jump_pulse, attack_pulse,
                 attacking, parrying, fsm_state, word_error};
            check("scoreboard", 32'(a), 32'(e));
         end
      end
   end

   task automatic hold(input logic [6:0] w, input int n);
      ctrl_word = w;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int p0, j0;
      logic [6:0] pool[11];
      pool = '{W_IDLE, W_LEFT, 7'b1100100, W_UP, 7'b1110000, W_ATK, W_PAR,
               W_BOTH, W_BAD, 7'b1100000, W_ATKUP};
      reset     = 1'b1;
      ctrl_word = W_IDLE;
      repeat (3) @(negedge clk);
      check("reset_state", 32'({move_left, move_right, crouch, jump_pulse, attack_pulse,
                                attacking, parrying, fsm_state, word_error}), 32'd0);
      reset = 1'b0;
      hold(W_IDLE, 8);

      // Bounce filter, then a clean hold of LEFT.
      for (int i = 0; i < 20; i++) begin
         ctrl_word = (((i / 2) % 2) == 0) ? W_LEFT : W_IDLE;
         @(negedge clk);
         check("bounce_no_move", 32'(move_left), 32'd0);
      end
      ctrl_word = W_LEFT;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 5) check("left_not_yet", 32'(move_left), 32'd0);
         if (i == 6) check("left_after_6", 32'(move_left), 32'd1);
      end
      hold(W_IDLE, 10);

      // Attack held through attack and cooldown.
      tick_period = 8;
      p0 = atk_pulses;
      hold(W_ATK, 200);
      check("attack_pulse_once", 32'(atk_pulses - p0), 32'd1);
      check("attack_back_idle", 32'(fsm_state), 32'd0);
      hold(W_IDLE, 10);

      // Parry held to timeout, then a short parry released early.
      tick_period = 4;
      hold(W_PAR, 220);
      check("parry_no_reentry", 32'(parrying), 32'd0);
      hold(W_IDLE, 60);
      hold(W_PAR, 27);
      hold(W_IDLE, 60);

      // Malformed word and simultaneous buttons.
      hold(W_BAD, 12);
      check("bad_word_error", 32'(word_error), 32'd1);
      check("bad_no_move", 32'({move_left, move_right, crouch}), 32'd0);
      hold(W_IDLE, 8);
      hold(W_BOTH, 10);
      check("both_attack", 32'(fsm_state), 32'd1);
      check("both_not_parry", 32'(parrying), 32'd0);
      hold(W_IDLE, 100);

      // Up edge dropped in ATTACK, honoured in COOLDOWN.
      tick_period = 8;
      j0 = jumps;
      hold(W_ATK, 20);
      hold(W_ATKUP, 15);
      hold(W_ATK, 40);
      check("jump_dropped_attack", 32'(jumps - j0), 32'd0);
      check("in_cooldown", 32'(fsm_state), 32'd3);
      hold(W_ATKUP, 15);
      check("jump_in_cooldown", 32'(jumps - j0), 32'd1);
      hold(W_IDLE, 120);

      // Reset mid-attack with the button still held.
      hold(W_ATK, 20);
      check("pre_reset_attack", 32'(attacking), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid_attack", 32'({move_left, move_right, crouch, jump_pulse, attack_pulse,
                                     attacking, parrying, fsm_state, word_error}), 32'd0);
      @(negedge clk);
      check("no_pulse_on_deassert", 32'(attack_pulse), 32'd0);
      hold(W_ATK, 20);
      hold(W_IDLE, 150);

      // Randomized traffic.
      tick_period = 0;
      for (int s = 0; s < 400; s++) begin
         ctrl_word = pool[$urandom_range(0, 10)];
         reset     = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         reset = 1'b0;
         repeat ($urandom_range(0, 9)) @(negedge clk);
      end
      hold(W_IDLE, 4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fighter_input_decoder.md
Name: fighter_input_decoder

Overview:
- Consumer end of the 7-bit controller word produced by the breadboard controller block.
- Filters glitches and rejects malformed words, then turns stable direction and button state into per-fighter game commands.
- Owns the attack/parry/cooldown state machine, timed in game frames.
- Sits between the controller interface and the fighter position/animation logic; one instance per player.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a new word is accepted (>=1).
- ATTACK_FRAMES, 6: frames spent in ATTACK.
- PARRY_MAX_FRAMES, 30: maximum frames a parry may be held.
- COOLDOWN_FRAMES, 10: recovery frames after an attack or parry.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ctrl_word  in  7  controller word:
  - bit0 center, bit1 left, bit2 right, bit3 up, bit4 down; direction bits are one-hot, active-high.
  - bit5 attack, active-low (0 = pressed); bit6 parry, active-low.
  - Idle word is 7'b1100001.
- frame_tick  in  1  one-cycle pulse per game frame
- move_left  out  1  level: walk left
- move_right  out  1  level: walk right
- crouch  out  1  level: crouch
- jump_pulse  out  1  one-cycle jump request
- attack_pulse  out  1  one-cycle pulse on entry to ATTACK
- attacking  out  1  high while in ATTACK
- parrying  out  1  high while in PARRY
- fsm_state  out  2  encoding: 0 IDLE, 1 ATTACK, 2 PARRY, 3 COOLDOWN
- word_error  out  1  stable word is malformed

Behaviour:
- Reset: the only clock is clk; reset is synchronous and active-high. Reset values:
  - Internal: stable_word = prev_word = 7'b1100001; sample register = 7'b1100001; all counters 0.
  - Outputs: fsm_state = IDLE; all outputs 0.
  - Reset asserted mid-operation aborts any state and takes effect at that edge, with no pending pulses.
- Stability filter:
  - Sample register in_q with run counter cnt.
  - If ctrl_word != in_q: in_q <= ctrl_word, cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt++.
  - Else: stable_word <= in_q.
  - A change held constant reaches stable_word STABLE_CYCLES+1 edges after it appears.
  - Any toggle restarts the count.
- Validity:
  - The stable word is valid iff exactly one of bits[4:0] is set.
  - If invalid: word_error = 1, and decoding uses the substitute word 7'b1100001 in place of the stable word. The substitution also applies to edge detection.
- Edge detection:
  - prev_word <= decoded word every cycle.
  - Press edge = bit transitions 1->0 for bit5/bit6, 0->1 for bit3.
- Output timing:
  - All outputs are registered and update one edge after stable_word changes.
  - Total input-to-output latency is STABLE_CYCLES+2 edges.
- Movement (IDLE and COOLDOWN only; forced 0 in ATTACK and PARRY):
  - move_left = bit1, move_right = bit2, crouch = bit4.
  - jump_pulse = one cycle on the up press edge. A jump edge occurring in ATTACK/PARRY is dropped, not queued.
- FSM; frame counter fcnt resets to 0 on every state entry:
  - IDLE:
    - attack press edge -> ATTACK, attack_pulse = 1 for exactly one cycle.
    - else parry press edge -> PARRY.
    - Attack wins if both edges occur in the same cycle.
  - ATTACK: fcnt++ per frame_tick; the tick with fcnt == ATTACK_FRAMES-1 -> COOLDOWN.
  - PARRY:
    - Parry release (bit6 == 1) -> COOLDOWN on the next edge.
    - The tick with fcnt == PARRY_MAX_FRAMES-1 -> COOLDOWN.
    - Release wins if it coincides with the timeout tick.
  - COOLDOWN: the tick with fcnt == COOLDOWN_FRAMES-1 -> IDLE. Button edges during COOLDOWN are ignored and not queued.
  - A frame_tick in the same cycle as a state entry is not counted.
  - Held buttons never retrigger; a fresh press edge is required.
- Counter widths: size cnt and fcnt with $clog2 of their maximum value, minimum 1 bit. Counters never wrap; they saturate at their terminal value.

Test Plan:
- Bounce filter: toggle ctrl_word between 7'b1100001 and 7'b1100010 every 2 cycles for 20 cycles -> move_left stays 0. Then hold 7'b1100010 -> move_left = 1 exactly 6 edges after the hold begins.
- Attack sequence: hold ctrl_word = 7'b1000001 with frame_tick every 8 cycles, ticks at fixed phase after entry ->
  - attack_pulse high exactly 1 cycle.
  - attacking high for exactly 6 ticks, then fsm_state = 3 for 10 ticks, then 0.
  - No second attack_pulse while the button stays held.
- Parry timeout vs release:
  - Hold bit6 = 0 -> parrying for 30 ticks then COOLDOWN, with no re-entry until release and re-press.
  - Separate run: release after 5 ticks -> COOLDOWN on the next edge.
- Malformed and simultaneous inputs:
  - Stable 7'b1100110 -> word_error = 1 and no movement outputs.
  - Stable 7'b0000001 pressed from IDLE -> ATTACK taken, not PARRY.
- Suppression and reset:
  - Up edge during ATTACK -> no jump_pulse; the same edge in COOLDOWN -> one jump_pulse.
  - Reset asserted mid-ATTACK -> next cycle fsm_state = 0, all outputs 0, and no attack_pulse on deassert while the button is still held.
